// File: rtl/cpu_pkg.sv
// Shared datapath definitions for the CPU.
//   DATA_W     : native datapath width
//   add_res_t  : packed adder result {cout, sum} at full datapath width
package cpu_pkg;

  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic              cout;
    logic [DATA_W-1:0] sum;
  } add_res_t;

endpackage

// File: rtl/half_adder_bit.sv
// One-bit half adder cell: sum = a ^ b, carry = a & b.
// Ports:
//   a_i, b_i  : operand bits
//   sum_o     : XOR of the operands
//   carry_o   : AND of the operands
module half_adder_bit (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;

endmodule

// File: rtl/half_adder_core.sv
// Leaf adder of the CPU datapath. Produces a zero-latency {cout, sum} = a + b and a
// registered copy loaded under en.
// Ports:
//   clk, rst_n    : clock and asynchronous active-low reset (registered outputs only)
//   a, b          : WIDTH-bit operands
//   en            : load enable for sum_q/cout_q
//   sum, cout     : combinational result, independent of clk/rst_n/en
//   sum_q, cout_q : registered result, held while en is low
//   valid_q       : high the cycle after a load
module half_adder_core
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             en,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             valid_q
);

  if (WIDTH < 1 || WIDTH > DATA_W) begin : gen_width_check
    $error("half_adder_core: WIDTH out of range");
  end

  // carry[i] is the carry into bit i; carry[WIDTH] is the carry-out.
  logic [WIDTH:1]   carry;
  logic [WIDTH-1:0] sum_w;

  // Bit 0 has no carry-in, so a single cell suffices.
  half_adder_bit u_ha_bit0 (
    .a_i    (a[0]),
    .b_i    (b[0]),
    .sum_o  (sum_w[0]),
    .carry_o(carry[1])
  );

  // Upper bits: two cascaded half adders plus an OR form a full adder (ripple).
  for (genvar i = 1; i < WIDTH; i++) begin : gen_ripple
    logic p;
    logic g;
    logic g_c;

    half_adder_bit u_ha_ab (
      .a_i    (a[i]),
      .b_i    (b[i]),
      .sum_o  (p),
      .carry_o(g)
    );

    half_adder_bit u_ha_cin (
      .a_i    (p),
      .b_i    (carry[i]),
      .sum_o  (sum_w[i]),
      .carry_o(g_c)
    );

    // Both partial carries can never be high together, so OR is exact.
    assign carry[i+1] = g | g_c;
  end

  assign sum  = sum_w;
  assign cout = carry[WIDTH];

  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             valid_d;

  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = en;
    if (en) begin
      sum_d  = sum;
      cout_d = cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_half_adder_core.sv
module tb_half_adder_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [0:0] a1, b1, sum1, sum1_q;
  logic       cout1, cout1_q, valid1_q;
  logic [7:0] a8, b8, sum8, sum8_q;
  logic       cout8, cout8_q, valid8_q;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  half_adder_core #(.WIDTH(1)) u_dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a1),
    .b      (b1),
    .en     (en),
    .sum    (sum1),
    .cout   (cout1),
    .sum_q  (sum1_q),
    .cout_q (cout1_q),
    .valid_q(valid1_q)
  );

  half_adder_core #(.WIDTH(8)) u_dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a8),
    .b      (b8),
    .en     (en),
    .sum    (sum8),
    .cout   (cout8),
    .sum_q  (sum8_q),
    .cout_q (cout8_q),
    .valid_q(valid8_q)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  // Expected {cout,sum} for {b,a} = 0..3, hand-computed.
  logic [1:0] exp1 [4] = '{2'b00, 2'b01, 2'b01, 2'b10};

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    a1 = 1'b1; b1 = 1'b1;
    a8 = 8'h00; b8 = 8'h00;
    #2;
    // Registers cleared during reset; combinational path still live.
    check_eq("rst_sum_q",   32'(sum1_q),   32'd0);
    check_eq("rst_cout_q",  32'(cout1_q),  32'd0);
    check_eq("rst_valid_q", 32'(valid1_q), 32'd0);
    check_eq("rst_comb",    32'({cout1, sum1}), 32'b10);
    check_eq("rst_sum8_q",  32'(sum8_q),   32'd0);

    #1 rst_n = 1'b1;

    // Exhaustive one-bit sweep, twice.
    for (int rep = 0; rep < 2; rep++) begin
      for (int v = 0; v < 4; v++) begin
        logic [1:0] vv;
        vv = 2'(v);
        {b1, a1} = vv;
        #5;
        check_eq($sformatf("sweep_%0d_%0d", rep, v), 32'({cout1, sum1}), 32'(exp1[v]));
      end
    end

    // First load after reset: 1+1.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    check_eq("load11_sum_q",   32'(sum1_q),   32'd0);
    check_eq("load11_cout_q",  32'(cout1_q),  32'd1);
    check_eq("load11_valid_q", 32'(valid1_q), 32'd1);

    // Load 1+0, then hold with en low while inputs change.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0;
    @(posedge clk); #1;
    check_eq("load10_sum_q",  32'(sum1_q),  32'd1);
    check_eq("load10_cout_q", 32'(cout1_q), 32'd0);
    @(negedge clk);
    en = 1'b0; a1 = 1'b1; b1 = 1'b1;
    @(posedge clk); #1;
    check_eq("hold_sum_q",   32'(sum1_q),   32'd1);
    check_eq("hold_cout_q",  32'(cout1_q),  32'd0);
    check_eq("hold_valid_q", 32'(valid1_q), 32'd0);
    check_eq("hold_comb",    32'({cout1, sum1}), 32'b10);

    // Asynchronous reset between edges.
    @(negedge clk);
    en = 1'b1; a1 = 1'b1; b1 = 1'b0;
    @(posedge clk); #1;
    check_eq("pre_rst_valid_q", 32'(valid1_q), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_sum_q",   32'(sum1_q),   32'd0);
    check_eq("async_valid_q", 32'(valid1_q), 32'd0);
    check_eq("async_comb",    32'({cout1, sum1}), 32'b01);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("reload_sum_q",   32'(sum1_q),   32'd1);
    check_eq("reload_valid_q", 32'(valid1_q), 32'd1);

    // Eight-bit wrap/carry vectors on the combinational path.
    a8 = 8'hFF; b8 = 8'h01; #5;
    check_eq("w8_ff_01", 32'({cout8, sum8}), 32'h100);
    a8 = 8'hFF; b8 = 8'hFF; #5;
    check_eq("w8_ff_ff", 32'({cout8, sum8}), 32'h1FE);
    a8 = 8'h0F; b8 = 8'h01; #5;
    check_eq("w8_0f_01", 32'({cout8, sum8}), 32'h010);
    a8 = 8'hA5; b8 = 8'h5A; #5;
    check_eq("w8_a5_5a", 32'({cout8, sum8}), 32'h0FF);
    a8 = 8'h80; b8 = 8'h80; #5;
    check_eq("w8_80_80", 32'({cout8, sum8}), 32'h100);

    // Eight-bit registered load of the wrap case.
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; en = 1'b1;
    @(posedge clk); #1;
    check_eq("w8_reg_sum_q",  32'(sum8_q),  32'hFE);
    check_eq("w8_reg_cout_q", 32'(cout8_q), 32'd1);
    check_eq("w8_reg_valid",  32'(valid8_q), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
